// File: rtl/led_shift_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_shift_driver_if
//  Description : Signal bundle between the LED shift driver, its frame
//                requester, the upstream 7-segment decoder and the external
//                74HC595-style shift-register chain.
//                master = the shift driver, slave = everything around it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_shift_driver_if;

    // Frame request side
    logic       start;
    logic [1:0] digit_count;
    logic       busy;
    logic       frame_done;

    // Decoder side
    logic       dec_led_data;
    logic       dec_busy;
    logic       dec_next_led;

    // Shift-register chain side
    logic       sr_data;
    logic       sr_clk;
    logic       sr_latch;

    modport master (
        input  start,
        input  digit_count,
        input  dec_led_data,
        input  dec_busy,
        output dec_next_led,
        output sr_data,
        output sr_clk,
        output sr_latch,
        output busy,
        output frame_done
    );

    modport slave (
        output start,
        output digit_count,
        output dec_led_data,
        output dec_busy,
        input  dec_next_led,
        input  sr_data,
        input  sr_clk,
        input  sr_latch,
        input  busy,
        input  frame_done
    );

endinterface
`default_nettype wire

// File: rtl/led_shift_driver.sv
`default_nettype none
// ============================================================================
//  Module      : led_shift_driver
//  Description : Paces the 7-segment decoder's serial segment stream with
//                dec_next_led strobes, shifts each bit into an external
//                74HC595-style chain (sr_data / sr_clk) and pulses sr_latch
//                to present the finished frame.
//                Optional feature macro: LED_AUTO_REFRESH_EN
//                  defined   -> frames are requested by a free-running
//                               refresh counter; start is ignored.
//                  undefined -> frames start only on accepted start pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_shift_driver #(
    parameter int CLK_DIV        = 4,       // clk cycles per sr_clk phase
    parameter int REFRESH_CYCLES = 100000   // auto-refresh period in clk cycles
) (
    input  logic                clk,
    input  logic                rst,
    led_shift_driver_if.master  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_PH_W    = $clog2(CLK_DIV + 1);
    localparam logic [c_PH_W-1:0] c_PH_LOAD = c_PH_W'(CLK_DIV - 1);
    localparam int              c_BIT_W   = 5;

    // Reject nonsensical configurations at elaboration time.
    generate
        if (CLK_DIV < 1 || REFRESH_CYCLES < 1) begin : g_bad_param
            $error("led_shift_driver: CLK_DIV and REFRESH_CYCLES must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SETTLE   = 3'd2,
        S_SETUP    = 3'd3,
        S_SHIFT_HI = 3'd4,
        S_ADVANCE  = 3'd5,
        S_LATCH    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [c_PH_W-1:0]    r_phase;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [c_BIT_W-1:0]   r_num_bits;

    logic                 w_start_req;
    logic                 w_accept;
    logic                 w_phase_done;
    logic                 w_last_bit;
    logic [c_BIT_W-1:0]   w_num_bits;

    logic                 r_dec_next_led;
    logic                 r_sr_data;
    logic                 r_sr_clk;
    logic                 r_sr_latch;
    logic                 r_busy;
    logic                 r_frame_done;

    // 7 segments per digit: 7*d computed as 8*d - d to stay in 5 bits.
    assign w_num_bits   = {bus.digit_count, 3'b000} - {3'b000, bus.digit_count};
    assign w_phase_done = (r_phase == '0);
    assign w_last_bit   = (r_bit_cnt == (r_num_bits - 5'd1));

    // ------------------------------------------------------------------------
    // Frame request source
    // ------------------------------------------------------------------------
`ifdef LED_AUTO_REFRESH_EN
    localparam int                c_REF_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_CYCLES - 1);

    logic [c_REF_W-1:0] r_refresh_cnt;
    logic               r_pending;
    logic               w_refresh_wrap;

    assign w_refresh_wrap = (r_refresh_cnt == c_REF_LAST);
    // A request is either a fresh wrap or one parked while a frame was running.
    assign w_start_req    = w_refresh_wrap | r_pending;

    // Free-running refresh counter; a wrap seen while busy is parked (depth 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_pending     <= 1'b0;
        end else begin
            r_refresh_cnt <= w_refresh_wrap ? '0 : r_refresh_cnt + 1'b1;
            if (w_accept) begin
                r_pending <= 1'b0;
            end else if (w_refresh_wrap) begin
                r_pending <= 1'b1;
            end
        end
    end
`else
    assign w_start_req = bus.start;
`endif

    // ------------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------------
    // Next-state logic; start is only looked at in IDLE so requests made
    // while a frame is running are dropped.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_req) begin
                    w_accept     = 1'b1;
                    w_state_next = (w_num_bits == '0) ? S_LATCH : S_LOAD;
                end
            end
            S_LOAD:     w_state_next = S_SETTLE;
            S_SETTLE:   w_state_next = S_SETUP;
            S_SETUP: begin
                if (w_phase_done) begin
                    w_state_next = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: begin
                if (w_phase_done) begin
                    w_state_next = w_last_bit ? S_LATCH : S_ADVANCE;
                end
            end
            S_ADVANCE:  w_state_next = S_SETTLE;
            S_LATCH: begin
                if (w_phase_done) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Phase counter counts down CLK_DIV-1..0 and reloads on every state change,
    // so each timed state lasts exactly CLK_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (w_state_next != r_state) begin
            r_phase <= c_PH_LOAD;
        end else if (!w_phase_done) begin
            r_phase <= r_phase - 1'b1;
        end
    end

    // Bit counter and frame length captured when a frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_num_bits <= '0;
        end else if (w_accept) begin
            r_bit_cnt  <= '0;
            r_num_bits <= w_num_bits;
        end else if (r_state == S_SHIFT_HI && w_phase_done) begin
            r_bit_cnt  <= r_bit_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    // Outputs are flops decoded from the next state, so each one is high for
    // exactly the cycles the FSM spends in the matching state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_next_led <= 1'b0;
            r_sr_clk       <= 1'b0;
            r_sr_latch     <= 1'b0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_dec_next_led <= (w_state_next == S_LOAD) || (w_state_next == S_ADVANCE);
            r_sr_clk       <= (w_state_next == S_SHIFT_HI);
            r_sr_latch     <= (w_state_next == S_LATCH);
            r_busy         <= (w_state_next != S_IDLE);
            r_frame_done   <= (w_state_next == S_DONE);
        end
    end

    // Serial data is captured once per bit as SETTLE ends, after the decoder
    // has had a cycle to update; once the decoder is idle the chain is padded
    // with 0 regardless of what its data line shows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr_data <= 1'b0;
        end else if (r_state == S_SETTLE) begin
            r_sr_data <= bus.dec_busy ? bus.dec_led_data : 1'b0;
        end
    end

    assign bus.dec_next_led = r_dec_next_led;
    assign bus.sr_data      = r_sr_data;
    assign bus.sr_clk       = r_sr_clk;
    assign bus.sr_latch     = r_sr_latch;
    assign bus.busy         = r_busy;
    assign bus.frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_led_shift_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_shift_driver
//  Description : Self-checking bench for led_shift_driver. A small decoder
//                model streams queued segment bits; every bit handed to the
//                decoder is also pushed as the expected sr_data value and
//                popped when the chain sees an sr_clk rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_shift_driver;

`ifdef LED_AUTO_REFRESH_EN
    localparam int CLK_DIV        = 1;
    localparam int REFRESH_CYCLES = 50;
`else
    localparam int CLK_DIV        = 2;
    localparam int REFRESH_CYCLES = 50;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_shift_driver_if bus ();

    led_shift_driver #(
        .CLK_DIV        (CLK_DIV),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic exp_q[$];     // expected sr_data per shift edge
    logic dec_bits[$];  // bits the decoder model will emit

    // Monitor statistics (only the monitor writes these)
    int   n_rise = 0, n_nl = 0, n_done = 0, n_latch = 0, n_viol = 0;
    int   last_done_cyc = 0;
    logic prev_clk = 1'b0, prev_data = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Decoder model: each strobe loads the next queued bit; with nothing left
    // it drops busy and shows garbage (1) on its data line.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dec_busy     <= 1'b0;
            bus.dec_led_data <= 1'b0;
        end else if (bus.dec_next_led) begin
            if (dec_bits.size() > 0) begin
                bus.dec_busy     <= 1'b1;
                bus.dec_led_data <= dec_bits.pop_front();
            end else begin
                bus.dec_busy     <= 1'b0;
                bus.dec_led_data <= 1'b1;
            end
        end
    end

    // Output monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.sr_clk && !prev_clk) begin
            n_rise++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL unexpected_shift: observed=1 expected=0 (no bit queued)");
            end else begin
                check("sr_data_bit", bus.sr_data, exp_q.pop_front());
            end
        end
        if (bus.sr_clk && bus.dec_next_led) n_viol++;
        if (bus.sr_clk && prev_clk && (bus.sr_data !== prev_data)) n_viol++;
        if (bus.dec_next_led) n_nl++;
        if (bus.sr_latch) n_latch++;
        if (bus.frame_done) begin
            n_done++;
            last_done_cyc = cyc;
        end
        prev_clk  = bus.sr_clk;
        prev_data = bus.sr_data;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Queue a frame: decoder supplies ndec bits, frame shifts nframe bits.
    task automatic load_bits(input int ndec, input int nframe, input logic [20:0] pat);
        for (int i = 0; i < nframe; i++) begin
            if (i < ndec) dec_bits.push_back(pat[i]);
            exp_q.push_back((i < ndec) ? pat[i] : 1'b0);
        end
    endtask

    task automatic pulse_start(input logic [1:0] dc);
        bus.digit_count = dc;
        bus.start       = 1'b1;
        tick(1);
        bus.start       = 1'b0;
    endtask

    task automatic wait_done(input int done0, input int max_cyc, output bit timeout);
        for (int k = 0; k < max_cyc; k++) begin
            if (n_done != done0) break;
            tick(1);
        end
        timeout = (n_done == done0);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_next_led"}, bus.dec_next_led, 0);
        check({pfx, "_sr_data"},  bus.sr_data,      0);
        check({pfx, "_sr_clk"},   bus.sr_clk,       0);
        check({pfx, "_sr_latch"}, bus.sr_latch,     0);
        check({pfx, "_busy"},     bus.busy,         0);
        check({pfx, "_done"},     bus.frame_done,   0);
    endtask

    initial begin
        int          s_cyc, d0, r0, nl0, l0;
        bit          to;
        logic [20:0] pat;

        bus.start       = 1'b0;
        bus.digit_count = 2'd0;
        rst             = 1'b1;
        tick(2);
        check_outputs_zero("reset");
        rst = 1'b0;
        tick(2);

`ifdef LED_AUTO_REFRESH_EN
        // Auto refresh: two digits, frames requested by the refresh counter.
        begin
            int c1, c2, c3, flen, lo, hi;
            bus.digit_count = 2'd2;
            bus.start       = 1'b0;
            for (int f = 0; f < 5; f++) load_bits(14, 14, 21'h0A5C3);
            wait_done(n_done, 400, to);
            check("auto_first_timeout", to, 0);
            c1 = last_done_cyc;
            wait_done(n_done, 400, to);
            check("auto_second_timeout", to, 0);
            c2 = last_done_cyc;
            wait_done(n_done, 400, to);
            check("auto_third_timeout", to, 0);
            c3 = last_done_cyc;
            flen = 14 * (2 * CLK_DIV + 2) + CLK_DIV + 1;
            lo   = (flen > REFRESH_CYCLES) ? flen : REFRESH_CYCLES;
            hi   = lo + 1;   // one IDLE cycle may separate back-to-back frames
            check("auto_spacing_1", ((c2 - c1) >= lo) && ((c2 - c1) <= hi), 1);
            check("auto_spacing_2", ((c3 - c2) >= lo) && ((c3 - c2) <= hi), 1);
            check("auto_next_led_vs_sr_clk", n_viol, 0);
        end
`else
        // 1) One digit, decoder runs dry after 6 bits -> last bit padded.
        load_bits(6, 7, 21'h3F);
        d0 = n_done; r0 = n_rise; nl0 = n_nl; l0 = n_latch;
        s_cyc = cyc;
        pulse_start(2'd1);
        wait_done(d0, 200, to);
        check("t1_timeout",         to, 0);
        check("t1_done_latency",    last_done_cyc - s_cyc, 45);
        check("t1_sr_clk_rises",    n_rise - r0, 7);
        check("t1_load_strobes",    (n_nl - nl0) > 0, 1);
        check("t1_advance_strobes", n_nl - nl0 - 1, 6);
        check("t1_latch_cycles",    n_latch - l0, CLK_DIV);
        check("t1_bits_left",       exp_q.size(), 0);
        tick(1);
        check("t1_busy_after",      bus.busy, 0);

        // 2) Zero digits: straight to latch.
        d0 = n_done; r0 = n_rise; nl0 = n_nl; l0 = n_latch;
        s_cyc = cyc;
        pulse_start(2'd0);
        wait_done(d0, 50, to);
        check("t2_timeout",      to, 0);
        check("t2_done_latency", last_done_cyc - s_cyc, 3);
        check("t2_next_led",     n_nl - nl0, 0);
        check("t2_sr_clk_rises", n_rise - r0, 0);
        check("t2_latch_cycles", n_latch - l0, CLK_DIV);
        tick(2);

        // 3) Three digits, second start mid-frame is ignored.
        pat = 21'($urandom);
        load_bits(21, 21, pat);
        d0 = n_done; r0 = n_rise;
        s_cyc = cyc;
        pulse_start(2'd3);
        tick(30);
        check("t3_busy_mid", bus.busy, 1);
        pulse_start(2'd1);
        wait_done(d0, 400, to);
        check("t3_timeout",      to, 0);
        check("t3_done_latency", last_done_cyc - s_cyc, 21 * (2 * CLK_DIV + 2) + CLK_DIV + 1);
        tick(60);
        check("t3_done_count",   n_done - d0, 1);
        check("t3_sr_clk_rises", n_rise - r0, 21);
        check("t3_busy_after",   bus.busy, 0);
        check("t3_bits_left",    exp_q.size(), 0);

        // 4) Reset during SHIFT_HI aborts at once, then a clean frame follows.
        load_bits(21, 21, 21'h1FFFFF);
        d0 = n_done; r0 = n_rise; l0 = n_latch;
        pulse_start(2'd3);
        to = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if ((n_rise - r0) >= 3 && bus.sr_clk) begin
                to = 1'b0;
                break;
            end
            tick(1);
        end
        check("t4_reach_shift_hi", to, 0);
        check("t4_sr_data_pre",    bus.sr_data, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("t4_async");
        exp_q.delete();
        dec_bits.delete();
        tick(2);
        rst = 1'b0;
        tick(1);
        check("t4_no_done",  n_done - d0, 0);
        check("t4_no_latch", n_latch - l0, 0);

        load_bits(7, 7, 21'b1010011);
        d0 = n_done; r0 = n_rise;
        s_cyc = cyc;
        pulse_start(2'd1);
        wait_done(d0, 200, to);
        check("t4b_timeout",      to, 0);
        check("t4b_done_latency", last_done_cyc - s_cyc, 45);
        check("t4b_sr_clk_rises", n_rise - r0, 7);
        check("t4b_bits_left",    exp_q.size(), 0);

        // 6) Strobe/shift-clock overlap and data stability across all frames.
        check("t6_protocol_violations", n_viol, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
